// File: rtl/mem_word_access.sv
// ---------------------------------------------------------------------------
// mem_word_access
//
// Purpose:
//   Byte-wide unified instruction/data memory with a word-access sequencer.
//   It sits directly after the IorD address mux. One request moves a 32-bit
//   big-endian word as four sequential byte beats. Beat 0 carries bits 31:24
//   and beat 3 carries bits 7:0. The completed read word goes to the
//   instruction register and the memory data register.
//
//   Timing of one access (the edge that samples start is edge 0):
//     - The first beat gets one settling cycle for the freshly latched
//       address. This cycle is spent in WAIT, so the first WAIT lasts
//       WAIT_STATES+1 cycles.
//     - Each later beat is preceded by exactly WAIT_STATES cycles in WAIT.
//     - Each beat takes one cycle in BEAT.
//     - FINISH follows the last beat. done is high there, 4*(1+WAIT_STATES)+1
//       edges after edge 0.
//
//   Byte addresses wrap modulo the memory depth.
//
// Parameters:
//   ADDR_WIDTH  - byte-address width; the memory holds 2**ADDR_WIDTH bytes.
//   WAIT_STATES - extra stall cycles before each byte beat (0..7).
//
// Configuration macro:
//   MEM_ALIGN_CHECK_EN - when defined, a start with address[1:0] != 0 goes
//                        straight to FINISH. In that FINISH cycle done and
//                        misaligned pulse together, and memory and read_data
//                        are left untouched. When undefined, misaligned is
//                        tied low and any byte address is accepted.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - asynchronous, active-high reset
//   start      - request pulse; sampled only in IDLE
//   write_en   - 1 = word write, 0 = word read; latched with start
//   address    - byte address from the IorD mux; latched with start
//   write_data - store data; latched with start
//   read_data  - last completed read word; held until the next read completes
//   busy       - high in WAIT, BEAT and FINISH
//   done       - one-cycle completion pulse
//   misaligned - one-cycle alignment error pulse (0 unless the macro is set)
// ---------------------------------------------------------------------------
module mem_word_access #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The first wait also covers the address settling cycle, so it is loaded
    // one higher than the waits between later beats.
    localparam logic [2:0] WAIT_LOAD_FIRST = 3'(WAIT_STATES);
    localparam logic [2:0] WAIT_LOAD_NEXT  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT,
        FINISH
    } state_t;

    state_t                state;
    logic [1:0]            beat;
    logic [2:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [23:0]           assembly_q;

    logic [7:0]            mem [DEPTH];

    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [7:0]            beat_wbyte;
    logic [7:0]            beat_rbyte;
    logic                  mem_we;

`ifdef MEM_ALIGN_CHECK_EN
    logic                  misaligned_q;
`endif

    // The byte touched by the current beat. The add wraps naturally at the
    // memory depth, so a word straddling the top of memory continues at 0.
    assign beat_addr  = addr_q + ADDR_WIDTH'(beat);
    assign beat_rbyte = mem[beat_addr];

    // Writes happen only while a write access is in BEAT. Reset drops the
    // state to IDLE immediately, so a partially written word keeps the bytes
    // already stored and receives no more.
    assign mem_we = (state == BEAT) && write_q;

    // Big-endian lane selection: beat 0 carries the most significant byte.
    always_comb begin
        beat_wbyte = 8'h00;
        case (beat)
            2'd0:    beat_wbyte = wdata_q[31:24];
            2'd1:    beat_wbyte = wdata_q[23:16];
            2'd2:    beat_wbyte = wdata_q[15:8];
            default: beat_wbyte = wdata_q[7:0];
        endcase
    end

    // The storage array has no reset. It is written one byte per beat and is
    // otherwise reached only through the sequencer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[beat_addr] <= beat_wbyte;
        end
    end

    // The sequencer does the following:
    //   - latches the request in IDLE;
    //   - counts wait cycles;
    //   - walks the four beats;
    //   - shifts read bytes into the assembly register.
    // read_data is loaded only when the last read beat lands. The full word
    // therefore appears together with done, and nothing partial is ever seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= 2'd0;
            wait_cnt   <= 3'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            assembly_q <= 24'h0;
            read_data  <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= address;
                        write_q <= write_en;
                        wdata_q <= write_data;
                        beat    <= 2'd0;
                        busy    <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        if (address[1:0] != 2'b00) begin
                            state        <= FINISH;
                            done         <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else
`endif
                        begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD_FIRST;
                        end
                    end
                end

                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= BEAT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                BEAT: begin
                    if (beat == 2'd3) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        if (!write_q) begin
                            read_data <= {assembly_q, beat_rbyte};
                        end
                    end else begin
                        beat <= beat + 2'd1;
                        if (!write_q) begin
                            assembly_q <= {assembly_q[15:0], beat_rbyte};
                        end
                        if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD_NEXT;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    misaligned_q <= 1'b0;
`endif
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_word_access.sv
// ---------------------------------------------------------------------------
// tb_mem_word_access
//
// Drives two instances of mem_word_access:
//   - dut1 with WAIT_STATES=0;
//   - dut2 with WAIT_STATES=2.
// A byte-array reference model assembles big-endian words with plain
// arithmetic. Expected latency comes from 4*(1+WAIT_STATES)+1, or 0 for a
// rejected misaligned request.
// ---------------------------------------------------------------------------
module tb_mem_word_access;

    int n_compared   = 0;
    int n_mismatched = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic        start1, we1;
    logic [7:0]  addr1;
    logic [31:0] wdata1, rdata1;
    logic        busy1, done1, mis1;

    logic        start2, we2;
    logic [7:0]  addr2;
    logic [31:0] wdata2, rdata2;
    logic        busy2, done2, mis2;

    logic [7:0]  ref_mem1 [256];
    logic [7:0]  ref_mem2 [256];
    logic [31:0] ref_last1;
    logic [31:0] ref_last2;

    always #5 clk = ~clk;

    mem_word_access #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .write_en(we1),
        .address(addr1), .write_data(wdata1), .read_data(rdata1),
        .busy(busy1), .done(done1), .misaligned(mis1)
    );

    mem_word_access #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .write_en(we2),
        .address(addr2), .write_data(wdata2), .read_data(rdata2),
        .busy(busy2), .done(done2), .misaligned(mis2)
    );

    // Every comparison goes through here so that the counters and the
    // failure report stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit ref_misaligned(input logic [7:0] a);
        return ALIGN_ON && (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_word(input bit sel, input logic [7:0] a);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] idx;
            idx = a + 8'(i);
            w = (w << 8) | 32'(sel ? ref_mem2[idx] : ref_mem1[idx]);
        end
        return w;
    endfunction

    // Applies one completed access to the model.
    task automatic ref_apply(input bit sel, input bit we, input logic [7:0] a,
                             input logic [31:0] d);
        if (!ref_misaligned(a)) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    logic [7:0] idx;
                    idx = a + 8'(i);
                    if (sel) ref_mem2[idx] = 8'(d >> (24 - 8 * i));
                    else     ref_mem1[idx] = 8'(d >> (24 - 8 * i));
                end
            end else begin
                if (sel) ref_last2 = ref_word(1'b1, a);
                else     ref_last1 = ref_word(1'b0, a);
            end
        end
    endtask

    function automatic logic cur_done(input bit sel);
        return sel ? done2 : done1;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy2 : busy1;
    endfunction

    // Runs one complete access on the selected instance and checks it:
    //   - latency;
    //   - busy coverage up to and including the done cycle;
    //   - read_data and misaligned during the done cycle;
    //   - done and busy both low one cycle later.
    // Request inputs are scrambled right after acceptance to show that the
    // access in flight uses only the latched copy.
    task automatic applyStimulus(input bit sel, input bit we, input logic [7:0] a,
                                 input logic [31:0] d, input string tag);
        int ws;
        int expect_edges;
        int edges;
        bit busy_ok;
        ws           = sel ? 2 : 0;
        expect_edges = ref_misaligned(a) ? 0 : 4 * (1 + ws) + 1;

        @(negedge clk);
        if (sel) begin start2 = 1'b1; we2 = we; addr2 = a; wdata2 = d; end
        else     begin start1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        @(posedge clk);
        #1;
        if (sel) begin
            start2 = 1'b0; we2 = 1'($urandom); addr2 = 8'($urandom); wdata2 = $urandom;
        end else begin
            start1 = 1'b0; we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = $urandom;
        end

        edges   = 0;
        busy_ok = 1'b1;
        while (!cur_done(sel) && edges < 40) begin
            if (!cur_busy(sel)) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end

        ref_apply(sel, we, a, d);
        checkOutput({tag, "/latency"}, 32'(edges), 32'(expect_edges));
        checkOutput({tag, "/busy_before_done"}, 32'(busy_ok), 32'd1);
        checkOutput({tag, "/busy_at_done"}, 32'(cur_busy(sel)), 32'd1);
        checkOutput({tag, "/read_data"}, sel ? rdata2 : rdata1, sel ? ref_last2 : ref_last1);
        checkOutput({tag, "/misaligned"}, 32'(sel ? mis2 : mis1), 32'(ref_misaligned(a)));

        @(posedge clk);
        #1;
        checkOutput({tag, "/done_pulse_end"}, 32'(cur_done(sel)), 32'd0);
        checkOutput({tag, "/busy_idle"}, 32'(cur_busy(sel)), 32'd0);
    endtask

    // Global watchdog so that a stuck sequencer cannot hang the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_done;
        logic [31:0] rnd_data;
        logic [7:0]  rnd_addr;
        bit          rnd_we;

        reset  = 1'b1;
        start1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 32'h0;
        start2 = 1'b0; we2 = 1'b0; addr2 = 8'h00; wdata2 = 32'h0;
        ref_last1 = 32'h0;
        ref_last2 = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ref_mem1[i] = 8'h00;
            ref_mem2[i] = 8'h00;
        end

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset/read_data1", rdata1, 32'h0);
        checkOutput("reset/busy1", 32'(busy1), 32'd0);
        checkOutput("reset/done1", 32'(done1), 32'd0);
        checkOutput("reset/misaligned1", 32'(mis1), 32'd0);
        checkOutput("reset/read_data2", rdata2, 32'h0);
        checkOutput("reset/busy2", 32'(busy2), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill dut1 with known random words so that every later read is defined.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i * 4), $urandom, "preload");
        end

        // Directed write then read at 0x10.
        applyStimulus(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, "wr10");
        applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, "rd10");
        checkOutput("rd10/const", rdata1, 32'hDEADBEEF);
        checkOutput("rd10/mem10", 32'(dut1.mem[8'h10]), 32'h0000_00DE);
        checkOutput("rd10/mem13", 32'(dut1.mem[8'h13]), 32'h0000_00EF);

`ifndef MEM_ALIGN_CHECK_EN
        // A word at 0xFE wraps around to bytes 0x00 and 0x01.
        applyStimulus(1'b0, 1'b1, 8'hFE, 32'h11223344, "wrFE");
        applyStimulus(1'b0, 1'b0, 8'hFE, 32'h0, "rdFE");
        checkOutput("wrap/const", rdata1, 32'h11223344);
        checkOutput("wrap/mem00", 32'(dut1.mem[8'h00]), 32'h0000_0033);
        checkOutput("wrap/mem01", 32'(dut1.mem[8'h01]), 32'h0000_0044);
`endif

        // A second start while busy must be ignored, not queued.
        @(negedge clk);
        start1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done1) n_done++;
        end
        ref_apply(1'b0, 1'b0, 8'h10, 32'h0);
        checkOutput("ignore/done_count", 32'(n_done), 32'd1);
        checkOutput("ignore/read_data", rdata1, ref_last1);
        checkOutput("ignore/const", rdata1, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 8'h20, 32'h0, "ignore/rd20");

        // Randomized accesses checked against the model, with addresses
        // anywhere in memory.
        for (int i = 0; i < 40; i++) begin
            rnd_we   = 1'($urandom);
            rnd_addr = 8'($urandom);
            rnd_data = $urandom;
            applyStimulus(1'b0, rnd_we, rnd_addr, rnd_data, "random");
        end

        // Two wait states per beat.
        applyStimulus(1'b1, 1'b1, 8'h10, 32'hCAFEF00D, "ws2/wr10");
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, "ws2/rd10");
        checkOutput("ws2/const", rdata2, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHECK_EN
        // A misaligned write is rejected immediately and leaves memory alone.
        applyStimulus(1'b0, 1'b1, 8'h21, 32'h9988_7766, "align/wr21");
        for (int i = 0; i < 5; i++) begin
            checkOutput("align/mem_unchanged", 32'(dut1.mem[8'h20 + 8'(i)]),
                        32'(ref_mem1[8'h20 + 8'(i)]));
        end
`endif

        // Reset in the middle of a write. Beats 0 and 1 land on edges 2 and 3,
        // and reset arrives just after edge 3.
        applyStimulus(1'b0, 1'b1, 8'h40, 32'h0000_0000, "rst/preload40");
        applyStimulus(1'b0, 1'b0, 8'h44, 32'h0, "rst/rd44");
        @(negedge clk);
        start1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst/busy", 32'(busy1), 32'd0);
        checkOutput("rst/done", 32'(done1), 32'd0);
        checkOutput("rst/read_data", rdata1, 32'h0);
        ref_mem1[8'h40] = 8'hAA;
        ref_mem1[8'h41] = 8'hBB;
        ref_last1 = 32'h0;
        ref_last2 = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst/mem40", 32'(dut1.mem[8'h40]), 32'h0000_00AA);
        checkOutput("rst/mem41", 32'(dut1.mem[8'h41]), 32'h0000_00BB);
        checkOutput("rst/mem42", 32'(dut1.mem[8'h42]), 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 8'h40, 32'h0, "rst/rd40");
        checkOutput("rst/rd40_const", rdata1, 32'hAABB0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
